// File: rtl/zbin_max_scheduler_pkg.sv
// Shared constants, FSM state type and result record for the z-bin max scheduler.
package zbin_max_scheduler_pkg;

   localparam int ZBINS       = 8;
   localparam int ZBIN_W      = 3;
   localparam int SEL_W       = 4;
   localparam int MX_LAT_DEF  = 4;
   localparam int WIDTH_DEF   = 32;
   localparam int SLICE_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One per-slice result at the default widths.
   typedef struct packed {
      logic [SLICE_W_DEF-1:0] slice;
      logic [ZBIN_W-1:0]      zbin;
      logic [WIDTH_DEF-1:0]   max;
   } zmax_result_t;

endpackage

// File: rtl/zbin_max_scheduler_fifo.sv
// Synchronous result FIFO: push and pop may coincide at any occupancy,
// head is read combinationally and holds until popped.
module zbin_max_scheduler_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 40,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          not_empty,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage array; no reset needed, occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign not_empty = (count != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      (push && !pop) |-> (count < CW'(DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      pop |-> (count != '0));

endmodule

// File: rtl/zbin_max_scheduler.sv
// Event scan sequencer: reads the 8 z-bin sums of every phi slice, hands them
// to the external pipelined max selector, tags the answers with their slice,
// queues them for the consumer and keeps the event-wide best.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; previous best_* held
//   ST_ISSUE | issuing slice reads while result credits are available
//   ST_DRAIN | all reads issued, waiting for the last selector answer
//   ST_DONE  | one-cycle done pulse, back to idle
module zbin_max_scheduler
   import zbin_max_scheduler_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NSLICE     = 27,
   parameter int SLICE_W    = 5,
   parameter int MX_LAT     = MX_LAT_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     rd_en,
   output logic [SLICE_W-1:0]       rd_addr,
   input  logic [ZBINS*WIDTH-1:0]   rd_data,
   output logic [ZBINS*WIDTH-1:0]   mx_in,
   input  logic [WIDTH-1:0]         mx_max,
   input  logic [SEL_W-1:0]         mx_sel,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [SLICE_W-1:0]       res_slice,
   output logic [ZBIN_W-1:0]        res_zbin,
   output logic [WIDTH-1:0]         res_max,
   output logic                     done,
   output logic [SLICE_W-1:0]       best_slice,
   output logic [ZBIN_W-1:0]        best_zbin,
   output logic [WIDTH-1:0]         best_max
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;
   localparam int RES_W = SLICE_W + ZBIN_W + WIDTH;
   localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NSLICE - 1);

   state_t               state_q, state_d;
   logic [SLICE_W-1:0]   addr_q;
   logic [MX_LAT:0]      pv_q;
   logic [SLICE_W-1:0]   ps_q [MX_LAT+1];
   logic [CNT_W-1:0]     inflight_q;
   logic [CNT_W-1:0]     fifo_count;
   logic [SUM_W-1:0]     used;
   logic                 credit_ok;
   logic                 issue;
   logic                 push;
   logic                 pop;
   logic                 start_ok;
   logic                 last_capture;
   logic [SLICE_W-1:0]   push_slice;
   logic [RES_W-1:0]     head;

   assign mx_in = rd_data;

   // A read may only go out if its answer is guaranteed a FIFO slot.
   assign used      = SUM_W'(inflight_q) + SUM_W'(fifo_count);
   assign credit_ok = (used < SUM_W'(FIFO_DEPTH));

   assign start_ok     = (state_q == ST_IDLE) && start;
   assign push         = pv_q[MX_LAT];
   assign push_slice   = ps_q[MX_LAT];
   assign last_capture = push && (push_slice == LAST_SLICE);
   assign pop          = res_valid && res_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state, read issue and done pulse.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (addr_q == LAST_SLICE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_capture) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign rd_en   = issue;
   assign rd_addr = addr_q;

   // Slice address: restarts on every accepted start, advances per issued read.
   always_ff @(posedge clk) begin
      if (reset)         addr_q <= '0;
      else if (start_ok) addr_q <= '0;
      else if (issue)    addr_q <= (addr_q == LAST_SLICE) ? '0 : addr_q + SLICE_W'(1);
   end

   // Valid pipe aligned with the read plus selector latency.
   always_ff @(posedge clk) begin
      if (reset) pv_q <= '0;
      else       pv_q <= {pv_q[MX_LAT-1:0], issue};
   end

   // Slice tags travel alongside the valid bits; only meaningful where valid.
   always_ff @(posedge clk) begin
      ps_q[0] <= addr_q;
      for (int i = 1; i <= MX_LAT; i++) ps_q[i] <= ps_q[i-1];
   end

   // Entries currently in the pipe; each one already owns a FIFO slot.
   always_ff @(posedge clk) begin
      if (reset) inflight_q <= '0;
      else       inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
   end

   // Event best: strict compare so the earliest slice keeps a tie.
   always_ff @(posedge clk) begin
      if (reset || start_ok) begin
         best_slice <= '0;
         best_zbin  <= '0;
         best_max   <= '0;
      end else if (push && (mx_max > best_max)) begin
         best_slice <= push_slice;
         best_zbin  <= mx_sel[ZBIN_W-1:0];
         best_max   <= mx_max;
      end
   end

   zbin_max_scheduler_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (RES_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({push_slice, mx_sel[ZBIN_W-1:0], mx_max}),
      .pop       (pop),
      .head_data (head),
      .not_empty (res_valid),
      .count     (fifo_count)
   );

   assign {res_slice, res_zbin, res_max} = head;

   a_sel_msb_zero: assert property (@(posedge clk) disable iff (reset)
      push |-> (mx_sel[SEL_W-1] == 1'b0));

endmodule

// File: tb/tb_zbin_max_scheduler.sv
// Bench for zbin_max_scheduler: behavioural bin memory and max selector around
// a 27-slice and a 4-slice instance, event-level scoreboard plus literal checks.
module tb_zbin_max_scheduler;
   import zbin_max_scheduler_pkg::*;

   localparam int W    = 32;
   localparam int NS_A = 27;
   localparam int NS_B = 4;
   localparam int LAT  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;

   logic         a_start = 1'b0, a_busy, a_rd_en, a_res_valid, a_res_ready = 1'b1, a_done;
   logic [4:0]   a_rd_addr, a_res_slice, a_best_slice;
   logic [255:0] a_rd_data = '0, a_mx_in;
   logic [31:0]  a_mx_max, a_res_max, a_best_max;
   logic [3:0]   a_mx_sel;
   logic [2:0]   a_res_zbin, a_best_zbin;

   logic         b_start = 1'b0, b_busy, b_rd_en, b_res_valid, b_done;
   logic         b_res_ready = 1'b1;
   logic [4:0]   b_rd_addr, b_res_slice, b_best_slice;
   logic [255:0] b_rd_data = '0, b_mx_in;
   logic [31:0]  b_mx_max, b_res_max, b_best_max;
   logic [3:0]   b_mx_sel;
   logic [2:0]   b_res_zbin, b_best_zbin;

   zbin_max_scheduler u_dut_a (
      .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .mx_in(a_mx_in),
      .mx_max(a_mx_max), .mx_sel(a_mx_sel),
      .res_valid(a_res_valid), .res_ready(a_res_ready), .res_slice(a_res_slice),
      .res_zbin(a_res_zbin), .res_max(a_res_max), .done(a_done),
      .best_slice(a_best_slice), .best_zbin(a_best_zbin), .best_max(a_best_max)
   );

   zbin_max_scheduler #(.NSLICE(NS_B)) u_dut_b (
      .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .mx_in(b_mx_in),
      .mx_max(b_mx_max), .mx_sel(b_mx_sel),
      .res_valid(b_res_valid), .res_ready(b_res_ready), .res_slice(b_res_slice),
      .res_zbin(b_res_zbin), .res_max(b_res_max), .done(b_done),
      .best_slice(b_best_slice), .best_zbin(b_best_zbin), .best_max(b_best_max)
   );

   // 8-input max, higher bin index wins on equality; returns {sel, max}.
   function automatic logic [35:0] sel8(input logic [255:0] v);
      logic [31:0] m;
      logic [3:0]  s;
      m = v[31:0];
      s = 4'd0;
      for (int k = 1; k < 8; k++) begin
         if (v[k*32 +: 32] >= m) begin
            m = v[k*32 +: 32];
            s = 4'(k);
         end
      end
      return {s, m};
   endfunction

   logic [255:0] mem_a [NS_A];
   logic [255:0] mem_b [NS_B];
   logic [35:0]  a_sp [LAT];
   logic [35:0]  b_sp [LAT];

   // Bin memories (1-cycle read) and 4-stage max selectors.
   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= (int'(a_rd_addr) < NS_A) ? mem_a[a_rd_addr] : '0;
      if (b_rd_en) b_rd_data <= (int'(b_rd_addr) < NS_B) ? mem_b[b_rd_addr[1:0]] : '0;
      a_sp[0] <= sel8(a_mx_in);
      b_sp[0] <= sel8(b_mx_in);
      for (int i = 1; i < LAT; i++) begin
         a_sp[i] <= a_sp[i-1];
         b_sp[i] <= b_sp[i-1];
      end
   end
   assign a_mx_sel = a_sp[LAT-1][35:32];
   assign a_mx_max = a_sp[LAT-1][31:0];
   assign b_mx_sel = b_sp[LAT-1][35:32];
   assign b_mx_max = b_sp[LAT-1][31:0];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ready_mode = 0;
   // res_ready driver for instance A: 0 always ready, 1 never, 2 random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       a_res_ready = 1'b1;
         1:       a_res_ready = 1'b0;
         default: a_res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Scoreboard state for instance A.
   zmax_result_t exp_q[$];
   zmax_result_t exp_best = '0;
   logic         model_open = 1'b0;
   logic         seen_rst = 1'b0;
   logic         last_rst = 1'b0;
   int           done_cnt = 0;
   int           rd_cnt = 0;
   logic [2:0]   got_zbin [NS_A];

   // Compare DUT A against the event model every cycle, then fold in inputs.
   always @(negedge clk) begin
      zmax_result_t r, eb;
      logic [35:0]  sv;
      if (last_rst) begin
         chk("rst_busy", a_busy, 0);
         chk("rst_rd_en", a_rd_en, 0);
         chk("rst_rd_addr", a_rd_addr, 0);
         chk("rst_done", a_done, 0);
         chk("rst_res_valid", a_res_valid, 0);
         chk("rst_best", {a_best_slice, a_best_zbin, a_best_max}, 0);
         exp_q.delete();
         exp_best = '0;
         model_open = 1'b0;
      end else if (seen_rst) begin
         chk("busy", a_busy, model_open);
         if (a_rd_en) rd_cnt++;
         if (a_done) begin
            done_cnt++;
            chk("done_only_in_event", 1'(model_open), 1);
            chk("best_at_done", {a_best_slice, a_best_zbin, a_best_max}, exp_best);
         end else if (!model_open) begin
            chk("best_hold", {a_best_slice, a_best_zbin, a_best_max}, exp_best);
         end
         if (a_res_valid) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", a_res_valid, 0);
            end else begin
               chk("res_head", {a_res_slice, a_res_zbin, a_res_max}, exp_q[0]);
               if (a_res_ready) begin
                  if (int'(a_res_slice) < NS_A) got_zbin[a_res_slice] = a_res_zbin;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
      if (!reset && seen_rst && a_start && !model_open) begin
         model_open = 1'b1;
         eb = '0;
         for (int s = 0; s < NS_A; s++) begin
            sv = sel8(mem_a[s]);
            r.slice = 5'(s);
            r.zbin  = sv[34:32];
            r.max   = sv[31:0];
            exp_q.push_back(r);
            if (r.max > eb.max) eb = r;
         end
         exp_best = eb;
      end else if (!last_rst && seen_rst && a_done) begin
         model_open = 1'b0;
      end
      if (reset) seen_rst = 1'b1;
      last_rst = reset;
   end

   // Collector for the 4-slice instance.
   zmax_result_t b_got[$];
   int b_first_cyc = -1;
   int b_done_cnt = 0;
   always @(negedge clk) begin
      zmax_result_t r;
      if (seen_rst && !reset) begin
         if (b_res_valid && b_first_cyc < 0) b_first_cyc = cyc;
         if (b_res_valid && b_res_ready) begin
            r.slice = b_res_slice;
            r.zbin  = b_res_zbin;
            r.max   = b_res_max;
            b_got.push_back(r);
         end
         if (b_done) b_done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_a();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input int limit);
      int d0 = done_cnt;
      for (int i = 0; i < limit && done_cnt == d0; i++) tick();
      chk("done_timeout", 1'(done_cnt != d0), 1);
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic fill_rand(input int hi);
      for (int s = 0; s < NS_A; s++)
         for (int k = 0; k < 8; k++) mem_a[s][k*32 +: 32] = $urandom_range(0, hi);
   endtask

   initial begin
      int s_cyc, r0, d0;
      zmax_result_t r;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Ramp pattern on both instances; 4-slice results pinned literally.
      for (int s = 0; s < NS_A; s++)
         for (int k = 0; k < 8; k++) mem_a[s][k*32 +: 32] = 32'(10 * s + k);
      for (int s = 0; s < NS_B; s++)
         for (int k = 0; k < 8; k++) mem_b[s][k*32 +: 32] = 32'(10 * s + k);
      a_start = 1'b1;
      b_start = 1'b1;
      s_cyc = cyc;
      tick();
      a_start = 1'b0;
      b_start = 1'b0;
      wait_done_a(300);
      wait_drain(100);
      chk("b_done_count", b_done_cnt, 1);
      chk("b_first_latency", b_first_cyc - s_cyc, 7);
      chk("b_result_count", b_got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         r = (i < b_got.size()) ? b_got[i] : '1;
         chk("b_result", {r.slice, r.zbin, r.max}, {5'(i), 3'd7, 32'(10 * i + 7)});
      end
      chk("b_best", {b_best_slice, b_best_zbin, b_best_max}, {5'd3, 3'd7, 32'd37});
      chk("b_busy_idle", b_busy, 0);
      chk("a_best_ramp", {a_best_slice, a_best_zbin, a_best_max}, {5'd26, 3'd7, 32'd267});

      // Single dominant bin.
      fill_rand(99);
      mem_a[2][3*32 +: 32] = 32'd500;
      pulse_a();
      wait_done_a(300);
      chk("t2_best", {a_best_slice, a_best_zbin, a_best_max}, {5'd2, 3'd3, 32'd500});
      @(negedge clk);
      chk("t2_busy_after_done", a_busy, 0);
      chk("t2_done_single", a_done, 0);
      tick();
      wait_drain(100);

      // Consumer stalled for the whole event: eight buffered, reads stall.
      fill_rand(1000);
      ready_mode = 1;
      tick();
      r0 = rd_cnt;
      d0 = done_cnt;
      pulse_a();
      repeat (60) tick();
      chk("t3_reads_before_stall", rd_cnt - r0, 8);
      chk("t3_no_done", done_cnt - d0, 0);
      chk("t3_res_valid", a_res_valid, 1);
      ready_mode = 0;
      wait_done_a(300);
      wait_drain(100);
      chk("t3_total_reads", rd_cnt - r0, 27);

      // Ties across slices and within a slice.
      fill_rand(99);
      mem_a[1][2*32 +: 32] = 32'd200;
      mem_a[1][5*32 +: 32] = 32'd200;
      mem_a[3][4*32 +: 32] = 32'd200;
      pulse_a();
      wait_done_a(300);
      wait_drain(100);
      chk("t4_best", {a_best_slice, a_best_zbin, a_best_max}, {5'd1, 3'd5, 32'd200});
      chk("t4_slice1_zbin", got_zbin[1], 5);
      chk("t4_slice3_zbin", got_zbin[3], 4);

      // Reset two cycles into a scan.
      fill_rand(50);
      d0 = done_cnt;
      pulse_a();
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      repeat (20) tick();
      chk("t5_no_res_valid", a_res_valid, 0);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_best_cleared", {a_best_slice, a_best_zbin, a_best_max}, 0);
      fill_rand(50);
      pulse_a();
      wait_done_a(300);
      wait_drain(100);

      // Start during drain is ignored; then an all-zero event.
      fill_rand(300);
      r0 = rd_cnt;
      d0 = done_cnt;
      pulse_a();
      for (int i = 0; i < 200 && rd_cnt - r0 < 27; i++) tick();
      chk("t6_reads_issued", rd_cnt - r0, 27);
      pulse_a();
      wait_done_a(100);
      repeat (10) tick();
      chk("t6_single_done", done_cnt - d0, 1);
      chk("t6_idle_after", a_busy, 0);
      wait_drain(100);
      for (int s = 0; s < NS_A; s++) mem_a[s] = '0;
      d0 = done_cnt;
      pulse_a();
      wait_done_a(300);
      wait_drain(100);
      chk("t6_zero_done", done_cnt - d0, 1);
      chk("t6_zero_best", {a_best_slice, a_best_zbin, a_best_max}, 0);

      // Random events under a randomly stalling consumer.
      ready_mode = 2;
      for (int e = 0; e < 4; e++) begin
         fill_rand(15);
         pulse_a();
         wait_done_a(1000);
      end
      ready_mode = 0;
      wait_drain(200);
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
